// File: rtl/fb_pkg.sv
// Frame-buffer geometry, write-path state encoding and address helpers
// shared by the write arbiter and the VGA address mapping.
package fb_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned X_MAX = 159;
  localparam int unsigned Y_MAX = 119;
  localparam int unsigned A_W   = X_W + Y_W;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    CLR_WAIT = 2'd1,
    CLR_RUN  = 2'd2
  } state_t;

  function automatic logic [A_W-1:0] fb_addr(input logic [Y_W-1:0] y,
                                             input logic [X_W-1:0] x);
    return {y, x};
  endfunction

  function automatic logic fb_in_range(input logic [X_W-1:0] x,
                                       input logic [Y_W-1:0] y);
    return (x <= X_W'(X_MAX)) && (y <= Y_W'(Y_MAX));
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester, clear-control, vsync and frame-buffer write signals of the
// write arbiter; slave is the arbiter side, master the surrounding system.
interface fb_write_arbiter_if;
  import fb_pkg::*;

  logic           R0_VALID;
  logic [X_W-1:0] R0_X;
  logic [Y_W-1:0] R0_Y;
  logic           R0_DATA;
  logic           R0_READY;
  logic           R1_VALID;
  logic [X_W-1:0] R1_X;
  logic [Y_W-1:0] R1_Y;
  logic           R1_DATA;
  logic           R1_READY;
  logic           CLEAR_START;
  logic           CLEAR_VALUE;
  logic           CLEAR_BUSY;
  logic           CLEAR_DONE;
  logic           VGA_VS;
  logic           FB_WE;
  logic [A_W-1:0] FB_WADDR;
  logic           FB_WDATA;

  modport slave (
    input  R0_VALID, R0_X, R0_Y, R0_DATA,
    input  R1_VALID, R1_X, R1_Y, R1_DATA,
    input  CLEAR_START, CLEAR_VALUE, VGA_VS,
    output R0_READY, R1_READY, CLEAR_BUSY, CLEAR_DONE,
    output FB_WE, FB_WADDR, FB_WDATA
  );

  modport master (
    output R0_VALID, R0_X, R0_Y, R0_DATA,
    output R1_VALID, R1_X, R1_Y, R1_DATA,
    output CLEAR_START, CLEAR_VALUE, VGA_VS,
    input  R0_READY, R1_READY, CLEAR_BUSY, CLEAR_DONE,
    input  FB_WE, FB_WADDR, FB_WDATA
  );

endinterface

// File: rtl/fb_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that
// wins a tie and flips to the other side after every grant.
module fb_rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic r_ptr;
  logic w_g0;
  logic w_g1;

  assign w_g0    = i_en & i_valid[0] & (~i_valid[1] | ~r_ptr);
  assign w_g1    = i_en & i_valid[1] & (~i_valid[0] |  r_ptr);
  assign o_grant = {w_g1, w_g0};

  always_ff @(posedge CLK) begin
    if (RESET)     r_ptr <= 1'b0;
    else if (w_g0) r_ptr <= 1'b1;
    else if (w_g1) r_ptr <= 1'b0;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Single write port of the 1-bit frame buffer: round-robin pixel writes from
// two requesters plus a whole-buffer clear engine, optionally vblank-aligned.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned WAIT_VBLANK = 1
) (
  input logic               CLK,
  input logic               RESET,
  fb_write_arbiter_if.slave bus
);

  state_t         r_state;
  logic [X_W-1:0] r_cx;
  logic [Y_W-1:0] r_cy;
  logic           r_val;
  logic           r_vs;
  logic           r_we;
  logic [A_W-1:0] r_waddr;
  logic           r_wdata;
  logic           r_done;

  logic           w_en;
  logic [1:0]     w_grant;
  logic           w_vs_fall;
  logic           w_x_last;
  logic           w_y_last;

  // Reset gates READY so requesters see no acceptance while held in reset.
  assign w_en      = (r_state == ARB) & ~RESET;
  assign w_vs_fall = r_vs & ~bus.VGA_VS;
  assign w_x_last  = (r_cx == X_W'(X_MAX));
  assign w_y_last  = (r_cy == Y_W'(Y_MAX));

  fb_rr_arb2 u_arb (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_en    (w_en),
    .i_valid ({bus.R1_VALID, bus.R0_VALID}),
    .o_grant (w_grant)
  );

  assign bus.R0_READY   = w_grant[0];
  assign bus.R1_READY   = w_grant[1];
  assign bus.CLEAR_BUSY = (r_state != ARB);
  assign bus.CLEAR_DONE = r_done;
  assign bus.FB_WE      = r_we;
  assign bus.FB_WADDR   = r_waddr;
  assign bus.FB_WDATA   = r_wdata;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ARB;
      r_cx    <= '0;
      r_cy    <= '0;
      r_val   <= 1'b0;
      r_vs    <= 1'b1;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_vs   <= bus.VGA_VS;
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ARB: begin
          // Out-of-range requests are still granted (consumed) but never written.
          if (w_grant[0] && fb_in_range(bus.R0_X, bus.R0_Y)) begin
            r_we    <= 1'b1;
            r_waddr <= fb_addr(bus.R0_Y, bus.R0_X);
            r_wdata <= bus.R0_DATA;
          end else if (w_grant[1] && fb_in_range(bus.R1_X, bus.R1_Y)) begin
            r_we    <= 1'b1;
            r_waddr <= fb_addr(bus.R1_Y, bus.R1_X);
            r_wdata <= bus.R1_DATA;
          end
          if (bus.CLEAR_START) begin
            r_state <= (WAIT_VBLANK != 0) ? CLR_WAIT : CLR_RUN;
            r_val   <= bus.CLEAR_VALUE;
            r_cx    <= '0;
            r_cy    <= '0;
          end
        end
        CLR_WAIT: begin
          if (w_vs_fall) r_state <= CLR_RUN;
        end
        CLR_RUN: begin
          r_we    <= 1'b1;
          r_waddr <= fb_addr(r_cy, r_cx);
          r_wdata <= r_val;
          if (w_x_last) begin
            r_cx <= '0;
            if (w_y_last) begin
              r_cy    <= '0;
              r_state <= ARB;
              r_done  <= 1'b1;
            end else begin
              r_cy <= r_cy + Y_W'(1);
            end
          end else begin
            r_cx <= r_cx + X_W'(1);
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomised scoreboard bench for fb_write_arbiter: a pixel-level reference
// model predicts grants and frame-buffer writes; a monitor checks each write.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int W = 160;
  localparam int H = 120;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  fb_write_arbiter_if bus ();

  fb_write_arbiter #(.WAIT_VBLANK(1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_cidx = -1;

  typedef struct {
    int tag;
    int addr;
    int data;
    int cidx;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int addr, input int data, input int cidx);
    exp_t e;
    e.tag  = cyc + 1;
    e.addr = addr;
    e.data = data;
    e.cidx = cidx;
    q.push_back(e);
  endtask

  function automatic bit in_range(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Reference model: mode 0 = accepting pixels, 1 = clear waiting for vsync,
  // 2 = clearing; k counts clear pixels in raster order.
  int mode = 0, ptr = 0, vs_prev = 1, k = 0, cval = 0, done_tag = -1;

  initial forever begin
    int win;
    @(negedge CLK);
    chk("clear_busy", {31'd0, bus.CLEAR_BUSY}, {31'd0, mode != 0});
    chk("clear_done", {31'd0, bus.CLEAR_DONE}, {31'd0, cyc == done_tag});
    win = -1;
    if (!RESET && mode == 0) begin
      if (bus.R0_VALID && !bus.R1_VALID)      win = 0;
      else if (bus.R1_VALID && !bus.R0_VALID) win = 1;
      else if (bus.R0_VALID && bus.R1_VALID)  win = ptr;
    end
    chk("r0_ready", {31'd0, bus.R0_READY}, {31'd0, win == 0});
    chk("r1_ready", {31'd0, bus.R1_READY}, {31'd0, win == 1});
    if (RESET) begin
      mode = 0; ptr = 0; vs_prev = 1; done_tag = -1;
    end else begin
      case (mode)
        0: begin
          if (win == 0) begin
            if (in_range(int'(bus.R0_X), int'(bus.R0_Y)))
              push(int'(bus.R0_Y) * 256 + int'(bus.R0_X), int'(bus.R0_DATA), -1);
            ptr = 1;
          end else if (win == 1) begin
            if (in_range(int'(bus.R1_X), int'(bus.R1_Y)))
              push(int'(bus.R1_Y) * 256 + int'(bus.R1_X), int'(bus.R1_DATA), -1);
            ptr = 0;
          end
          if (bus.CLEAR_START) begin
            mode = 1; cval = int'(bus.CLEAR_VALUE); k = 0;
          end
        end
        1: if (vs_prev == 1 && bus.VGA_VS == 1'b0) mode = 2;
        default: begin
          push((k / W) * 256 + (k % W), cval, k);
          k++;
          if (k == W * H) begin
            mode = 0; done_tag = cyc + 1;
          end
        end
      endcase
      vs_prev = int'(bus.VGA_VS);
    end
  end

  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (bus.FB_WE === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_cycle", cyc, e.tag);
        chk("wr_addr", {17'd0, bus.FB_WADDR}, e.addr);
        chk("wr_data", {31'd0, bus.FB_WDATA}, e.data);
        if (e.cidx >= 0) last_cidx = e.cidx;
      end
    end else if (q.size() > 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      chk("missing_we", {31'd0, bus.FB_WE}, 32'd1);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.R0_VALID = 1'b0; bus.R1_VALID = 1'b0;
    bus.CLEAR_START = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.R0_VALID = 1'($urandom_range(0, 1));
      bus.R1_VALID = 1'($urandom_range(0, 1));
      bus.R0_X = X_W'($urandom_range(0, 170));
      bus.R1_X = X_W'($urandom_range(0, 170));
      bus.R0_Y = Y_W'($urandom_range(0, 125));
      bus.R1_Y = Y_W'($urandom_range(0, 125));
      bus.R0_DATA = 1'($urandom_range(0, 1));
      bus.R1_DATA = 1'($urandom_range(0, 1));
      step();
    end
    idle_inputs();
  endtask

  initial begin
    bit done_seen;
    int budget;
    // Reset with every input active.
    bus.R0_VALID = 1'b1; bus.R0_X = 8'd1; bus.R0_Y = 7'd1; bus.R0_DATA = 1'b1;
    bus.R1_VALID = 1'b1; bus.R1_X = 8'd2; bus.R1_Y = 7'd2; bus.R1_DATA = 1'b1;
    bus.CLEAR_START = 1'b1; bus.CLEAR_VALUE = 1'b1; bus.VGA_VS = 1'b1;
    RESET = 1'b1;
    step();
    chk("rst_we", {31'd0, bus.FB_WE}, 32'd0);
    chk("rst_waddr", {17'd0, bus.FB_WADDR}, 32'd0);
    chk("rst_wdata", {31'd0, bus.FB_WDATA}, 32'd0);
    step();
    RESET = 1'b0;
    idle_inputs();
    chk("post_rst_we", {31'd0, bus.FB_WE}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.CLEAR_BUSY}, 32'd0);
    chk("post_rst_done", {31'd0, bus.CLEAR_DONE}, 32'd0);
    step();

    // Single write.
    bus.R0_VALID = 1'b1; bus.R0_X = 8'd5; bus.R0_Y = 7'd3; bus.R0_DATA = 1'b1;
    step();
    idle_inputs();
    chk("single_we", {31'd0, bus.FB_WE}, 32'd1);
    chk("single_addr", {17'd0, bus.FB_WADDR}, 32'h0305);

    // Out-of-range X is consumed without a write.
    bus.R1_VALID = 1'b1; bus.R1_X = 8'd160; bus.R1_Y = 7'd0; bus.R1_DATA = 1'b1;
    step();
    idle_inputs();
    chk("range_we", {31'd0, bus.FB_WE}, 32'd0);

    // Both held: grants must alternate starting with R0.
    for (int i = 0; i < 6; i++) begin
      bus.R0_VALID = 1'b1; bus.R0_X = X_W'(i);      bus.R0_Y = 7'd10; bus.R0_DATA = 1'b1;
      bus.R1_VALID = 1'b1; bus.R1_X = X_W'(i + 20); bus.R1_Y = 7'd11; bus.R1_DATA = 1'b0;
      step();
    end
    idle_inputs();
    step();

    rand_cycles(400);

    // Clear waiting for vblank, R0 held throughout.
    bus.R0_VALID = 1'b1; bus.R0_X = 8'd7; bus.R0_Y = 7'd7; bus.R0_DATA = 1'b1;
    bus.CLEAR_START = 1'b1; bus.CLEAR_VALUE = 1'b0;
    step();
    bus.CLEAR_START = 1'b0;
    chk("busy_immediate", {31'd0, bus.CLEAR_BUSY}, 32'd1);
    repeat (50) step();
    bus.VGA_VS = 1'b0;
    repeat (5) step();
    bus.VGA_VS = 1'b1;
    repeat (100) step();
    bus.CLEAR_START = 1'b1; bus.CLEAR_VALUE = 1'b1;
    step();
    bus.CLEAR_START = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20000 && !done_seen; i++) begin
      step();
      if (bus.CLEAR_DONE === 1'b1) done_seen = 1'b1;
    end
    chk("clear_done_seen", {31'd0, done_seen}, 32'd1);
    repeat (3) step();
    idle_inputs();
    step();

    // Second clear, abandoned by reset after about 1000 writes.
    bus.CLEAR_START = 1'b1; bus.CLEAR_VALUE = 1'b1;
    step();
    bus.CLEAR_START = 1'b0;
    repeat (10) step();
    bus.VGA_VS = 1'b0;
    last_cidx = -1;
    budget = 0;
    while (last_cidx < 999 && budget < 3000) begin
      step();
      budget++;
    end
    chk("clear2_reached_1000", {31'd0, last_cidx >= 999}, 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("midclr_rst_we", {31'd0, bus.FB_WE}, 32'd0);
    chk("midclr_rst_busy", {31'd0, bus.CLEAR_BUSY}, 32'd0);
    bus.VGA_VS = 1'b1;
    repeat (30) step();

    rand_cycles(200);
    repeat (4) step();
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Owns the single write port of the 1-bit dual-port frame buffer that the VGA signal generator reads.
- Shares that port between two pixel-write requesters: R0, the microprocessor bus bridge, and R1, the drawing engine. Uses round-robin arbitration with a valid/ready handshake.
- Contains a clear engine that fills the whole buffer with one value. The clear can optionally be held until the next vertical sync pulse so it starts in blanking.

Parameters:
- X_W, 8, width of the pixel X coordinate.
- Y_W, 7, width of the pixel Y coordinate.
- X_MAX, 159, last valid X; the buffer is 160 pixels wide.
- Y_MAX, 119, last valid Y; the buffer is 120 pixels tall.
- WAIT_VBLANK, 1, when 1 a clear waits for the VGA_VS falling edge before writing.

Ports:
- CLK, in, 1, system clock.
- RESET, in, 1, reset; synchronous, active-high; clock CLK.
- R0_VALID, in, 1, R0 write request.
- R0_X, in, X_W, R0 pixel X.
- R0_Y, in, Y_W, R0 pixel Y.
- R0_DATA, in, 1, R0 pixel value.
- R0_READY, out, 1, R0 request accepted this cycle.
- R1_VALID / R1_X / R1_Y / R1_DATA / R1_READY: same as R0, for R1.
- CLEAR_START, in, 1, single-cycle pulse requesting a clear.
- CLEAR_VALUE, in, 1, fill value, sampled on an accepted CLEAR_START.
- CLEAR_BUSY, out, 1, high from an accepted start until the last clear write is issued.
- CLEAR_DONE, out, 1, one-cycle pulse on the cycle after the last clear write.
- VGA_VS, in, 1, active-low vsync from the signal generator.
- FB_WE, out, 1, frame buffer write enable.
- FB_WADDR, out, X_W+Y_W, write address {Y,X}.
- FB_WDATA, out, 1, write data.

Behaviour:
- Reset values: FB_WE=0, FB_WADDR=0, FB_WDATA=0, CLEAR_BUSY=0, CLEAR_DONE=0, both READY=0. State=ARB, round-robin pointer=R0, clear counters=0, VS history register=1.
- All FB_* outputs are registered. A handshake (VALID & READY) in cycle N produces FB_WE=1 with that address and data in cycle N+1. At most one write is issued per cycle.
- READY is combinational from state, pointer and VALIDs:
  - READYn=1 only in state ARB, when VALIDn=1 and requester n wins.
  - If only one VALID is high, that requester wins.
  - If both are high, the pointer decides.
  - After a grant to n the pointer moves to the other requester. The pointer does not move when nothing is granted.
- Out-of-range request (X>X_MAX or Y>Y_MAX): READY is still asserted so the request is consumed, but FB_WE stays 0 next cycle. The pointer still advances.
- State machine:
  - ARB, with CLEAR_START=1: if WAIT_VBLANK=1 go to CLR_WAIT, else go to CLR_RUN. Latch CLEAR_VALUE and set CLEAR_BUSY. A requester handshake in that same cycle is still honoured.
  - CLR_WAIT: READY=0. Move to CLR_RUN on a VGA_VS falling edge (previous sample 1, current sample 0).
  - CLR_RUN: READY=0. Each cycle issue a write at {cy,cx} with the latched value, X fastest, from (0,0) to (X_MAX,Y_MAX).
    - On X_MAX, cx wraps to 0 and cy increments.
    - The write at (X_MAX,Y_MAX) is the last one. The next state is ARB, CLEAR_BUSY drops, and CLEAR_DONE pulses.
  - The clear therefore takes (X_MAX+1)*(Y_MAX+1)=19200 consecutive FB_WE cycles.
- CLEAR_START outside ARB is ignored; it is not queued.
- Requesters are not starved by each other: with both VALID held high, grants alternate every cycle.
- RESET during CLR_WAIT or CLR_RUN abandons the clear. The next cycle shows reset values; no CLEAR_DONE is produced. Buffer contents are left partially cleared.
- VALID may drop without a handshake; no request is stored inside the block.

Decomposition:
- Shared package fb_pkg holds:
  - the X_W, Y_W, X_MAX and Y_MAX constants, shared with the VGA address mapping;
  - the state enum {ARB, CLR_WAIT, CLR_RUN};
  - an address-pack function returning {Y,X}.
- One natural sub-module, fb_rr_arb2: a two-requester round-robin arbiter with pointer register, producing READY/grant.
- The clear FSM and output registers stay in the top level.

Test Plan:
- Reset: assert RESET for 2 cycles with all inputs active -> all outputs 0 during reset and on the first cycle after release.
- Single write: R0 with X=5, Y=3, DATA=1 for one cycle -> R0_READY=1 that cycle; next cycle FB_WE=1, FB_WADDR=0x0305, FB_WDATA=1.
- Fairness: R0 and R1 VALID held for 6 cycles -> grants R0,R1,R0,R1,R0,R1; FB_WE=1 on 6 consecutive cycles with matching addresses.
- Range check: R1 with X=160, Y=0 -> R1_READY=1; next cycle FB_WE=0.
- Clear with WAIT_VBLANK=1: pulse CLEAR_START with CLEAR_VALUE=0, then VGA_VS falls 50 cycles later. Expected:
  - CLEAR_BUSY=1 immediately;
  - no FB_WE until the falling edge;
  - then 19200 writes, first address 0x0000, last 0x779F;
  - CLEAR_DONE is a one-cycle pulse after the last write;
  - R0 held VALID throughout sees READY=0 until state returns to ARB.
- Reset mid-clear: RESET at clear write 1000 -> FB_WE=0 and CLEAR_BUSY=0 next cycle; CLEAR_DONE never pulses.
